// File: rtl/deser1_64.sv
// Serial-to-parallel deserializer: collects WIDTH bits (bit k = k-th accepted bit) into a word
// presented on a registered valid/ready output, with one extra word of buffering before stalling.
module deser1_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] STALL   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept, consume, last_bit;
  logic [WIDTH-1:0] full_word;

  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign last_bit  = (count_q == CNT_W'(WIDTH - 1));
  assign full_word = {in, shreg_q[WIDTH-2:0]};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;

    // A consume empties the output unless a new word is loaded below.
    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      count_d = '0;
      shreg_d = '0;
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (last_bit) begin
              count_d = '0;
              if (!out_valid_q || consume) begin
                out_d       = full_word;
                out_valid_d = 1'b1;
              end else begin
                shreg_d = full_word;
                state_d = STALL;
              end
            end else begin
              shreg_d[count_q] = in;
              count_d          = count_q + 1'b1;
            end
          end
        end
        STALL: begin
          if (consume) begin
            out_d       = shreg_q;
            out_valid_d = 1'b1;
            shreg_d     = '0;
            state_d     = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      shreg_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_deser1_64.sv
// Randomized bench for deser1_64: a word-queue model checked every cycle, directed literal
// checks, and a mux-driven round-trip scoreboard.
module tb_deser1_64;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             reset, flush, s_in, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] out;
  logic [5:0]       count;

  deser1_64 #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in        (s_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int or_duty = 100;
  logic chk_en = 1'b0;
  logic sb_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: completed words waiting to be read (head is on out, a second one means stalled).
  logic [63:0] m_q[$];
  logic [63:0] m_last = '0;
  logic [63:0] m_bits = '0;
  int          m_n = 0;

  always @(posedge clk) begin
    logic acc, con;
    acc = in_valid && (m_q.size() < 2);
    con = out_ready && (m_q.size() > 0);
    if (reset) begin
      m_q.delete();
      m_last = '0;
      m_bits = '0;
      m_n    = 0;
    end else begin
      if (flush && m_q.size() == 2) void'(m_q.pop_back());
      if (con) m_last = m_q.pop_front();
      if (flush) begin
        m_bits = '0;
        m_n    = 0;
      end else if (acc) begin
        m_bits[m_n] = s_in;
        m_n++;
        if (m_n == WIDTH) begin
          m_q.push_back(m_bits);
          m_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", out, (m_q.size() > 0) ? m_q[0] : m_last);
      chk("model_out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      chk("model_in_ready", 64'(in_ready), 64'(m_q.size() < 2));
      chk("model_count", 64'(count), 64'(m_n));
    end
  end

  // Round-trip scoreboard: source vectors in completion order.
  logic [63:0] exp_q[$];
  always @(posedge clk) begin
    if (sb_en && !reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("rt_unexpected_word", out, 64'hx);
      else chk("rt_word", out, exp_q.pop_front());
    end
  end

  task automatic send_bit(input logic b, input int duty, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      s_in      = b;
      flush     = 1'b0;
      in_valid  = ($urandom_range(99) < duty);
      out_ready = ($urandom_range(99) < or_duty);
      got       = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!got) chk("send_timeout", 64'(got), 64'd1);
  endtask

  task automatic send_word(input logic [63:0] w, input int duty, output int cyc);
    int c;
    cyc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i], duty, c);
      cyc += c;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = ordy;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    s_in      = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'($urandom);
    s_in      = 1'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    logic [63:0] vec, xw;
    logic aborted;
    reset = 1'b0; flush = 1'b0; s_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; s_in = 1'($urandom); in_valid = 1'($urandom);
      out_ready = 1'($urandom); flush = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_out", out, 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    flush = 1'b0;
    chk_en = 1'b1;

    // Continuous stream, back-to-back words.
    or_duty = 100;
    send_word(64'hDEADBEEF_01234567, 100, cyc);
    chk("cont_cycles0", 64'(cyc), 64'd64);
    chk("cont_out0", out, 64'hDEADBEEF_01234567);
    chk("cont_valid0", 64'(out_valid), 64'd1);
    send_word(64'hFFFF0000_A5A5A5A5, 100, cyc);
    chk("cont_cycles1", 64'(cyc), 64'd64);
    chk("cont_out1", out, 64'hFFFF0000_A5A5A5A5);
    idle(1, 1'b1);
    chk("cont_pulse", 64'(out_valid), 64'd0);

    // Backpressure.
    or_duty = 0;
    send_word(64'h1, 100, cyc);
    chk("bp_out_a", out, 64'h1);
    send_word(64'h8000_0000_0000_0000, 100, cyc);
    chk("bp_stall_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_a", out, 64'h1);
    idle(1, 1'b1);
    chk("bp_out_b", out, 64'h8000_0000_0000_0000);
    chk("bp_valid_b", 64'(out_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    idle(1, 1'b1);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Sparse input.
    or_duty = 100;
    send_word(64'h01234567_89ABCDEF, 50, cyc);
    chk("sparse_out", out, 64'h01234567_89ABCDEF);
    idle(1, 1'b1);

    // Flush mid-word, then flush in stall.
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 100, cyc);
    chk("flush_pre_count", 64'(count), 64'd10);
    pulse_flush();
    chk("flush_count", 64'(count), 64'd0);
    send_word(64'hCAFEF00D_CAFEF00D, 100, cyc);
    chk("flush_out", out, 64'hCAFEF00D_CAFEF00D);
    or_duty = 0;
    xw = {$urandom, $urandom};
    send_word(xw, 100, cyc);
    chk("fstall_ready", 64'(in_ready), 64'd0);
    pulse_flush();
    chk("fstall_ready_back", 64'(in_ready), 64'd1);
    chk("fstall_out_kept", out, 64'hCAFEF00D_CAFEF00D);
    idle(1, 1'b1);
    chk("fstall_empty", 64'(out_valid), 64'd0);
    chk("fstall_no_stalled", out, 64'hCAFEF00D_CAFEF00D);

    // Round trip through a 64:1 mux source, one reset mid-word.
    sb_en = 1'b1;
    or_duty = 80;
    for (int w = 0; w < 1000; w++) begin
      vec = {$urandom, $urandom};
      aborted = 1'b0;
      for (int sel = 0; sel < WIDTH; sel++) begin
        if (w == 500 && sel == 30) begin
          do_reset();
          chk("rt_reset_count", 64'(count), 64'd0);
          chk("rt_reset_valid", 64'(out_valid), 64'd0);
          aborted = 1'b1;
          break;
        end
        send_bit(vec[sel], 90, cyc);
      end
      if (!aborted) exp_q.push_back(vec);
    end
    idle(4, 1'b1);
    chk("rt_drained", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
